niosqsys_gpio_pio: RTL and testbench
====================================

Name: niosqsys_gpio_pio

Overview:
Parametrised Avalon-MM slave general-purpose I/O port. It is the successor of the fixed 8-bit write-only output PIO.
- Adds configurable width and per-bit direction control.
- Adds atomic bit set/clear registers.
- Adds a synchronised input path with edge capture and a maskable interrupt.
It sits on the Nios II data master bus and drives/samples board-level control pins.

Parameters:
WIDTH, 8, port width in bits (1..32)
RESET_VALUE, 0, reset value of the output data register (WIDTH bits)
EDGE_TYPE, 0, edge to capture: 0 rising, 1 falling, 2 any
IRQ_MODE, 1, 0 level (irq from synchronised input & mask), 1 edge (irq from edge capture & mask)
SYNC_STAGES, 2, input synchroniser depth (2..3)

Ports:
clk  in  1  system clock
reset_n  in  1  reset; asynchronous assert, active-low
address  in  3  word address of register
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data; bits [WIDTH-1:0] used
readdata  out  32  read data, combinational from address; bits above WIDTH read 0
in_port  in  WIDTH  asynchronous pin inputs
out_port  out  WIDTH  output data register
out_en  out  WIDTH  per-bit output enable (1 = drive pin)
irq  out  1  registered interrupt request

Behaviour:
- Single clock domain (clk). reset_n is asynchronous and active-low.
- Write occurs when chipselect=1 and write_n=0 at rising clk. Reads have zero wait states; readdata is valid in the same cycle as address.
- Register map:
  - 0 DATA: read = synchronised input (last sync stage); write = out_port.
  - 1 DIR: R/W, 1 = output; drives out_en.
  - 2 IRQMASK: R/W.
  - 3 EDGECAP: read = capture bits; write-1-to-clear.
  - 4 OUTSET: write-only; out_port |= wd. Reads 0.
  - 5 OUTCLR: write-only; out_port &= ~wd. Reads 0.
  - 6, 7: reserved; reads 0, writes ignored.
- Reset values:
  - out_port = RESET_VALUE.
  - out_en, IRQMASK, EDGECAP = 0; irq = 0.
  - Sync stages and previous-sample register = 0.
  - Arm counter = 0.
- Synchroniser: in_port passes through SYNC_STAGES flops (s_last); a further register holds prev = s_last delayed by one cycle.
- Edge detect per bit:
  - rise = s_last & ~prev
  - fall = ~s_last & prev
  - any = s_last ^ prev
  - The edge is qualified by armed.
- Arm counter: counts cycles after reset release. armed asserts once SYNC_STAGES+1 cycles have elapsed. This suppresses spurious edges from pins already high at reset. It saturates and never re-arms except via reset.
- Latency: an in_port change stable before rising edge k gives:
  - DATA read reflects it after edge k+SYNC_STAGES-1.
  - EDGECAP bit set after edge k+SYNC_STAGES.
  - irq asserts after edge k+SYNC_STAGES+1.
- EDGECAP set/clear collision: a new edge on a bit in the same cycle as a write-1-to-clear of that bit leaves the bit 1 (set wins). Bits written 0 are unaffected.
- irq register next state:
  - IRQ_MODE=1: |(EDGECAP & IRQMASK)
  - IRQ_MODE=0: |(s_last & IRQMASK)
  - A mask or EDGECAP change is reflected on irq one cycle later.
- Bits with out_en=0 still hold and update out_port. Only the pin driver is disabled.
- Pulses on in_port shorter than one clk period may be missed; no requirement applies to them.
- Reset asserted mid-operation returns all state to reset values immediately, regardless of clk. Captures are lost.

Test Plan:
1. Reset with in_port=8'hFF held -> after release, DATA reads 8'hFF by cycle 2; EDGECAP stays 8'h00 for 10 cycles; irq=0; out_port=RESET_VALUE.
2. Write DATA=8'hA5, then OUTSET=8'h0A -> out_port=8'hAF; then OUTCLR=8'h21 -> out_port=8'h8E; readback of addr 4/5 = 0.
3. EDGE_TYPE=0, IRQMASK=8'h01: in_port bit0 0->1 before edge k -> EDGECAP=8'h01 after k+2, irq=1 after k+3. A 1->0 transition sets nothing.
4. With EDGECAP=8'h01, write EDGECAP=8'h01 in the same cycle a new rising edge on bit0 is detected -> EDGECAP remains 8'h01. A later clear with no edge -> 8'h00; irq drops one cycle later.
5. IRQ_MODE=0, IRQMASK=8'h80: in_port[7]=1 -> irq=1 (after SYNC_STAGES+1 edges). Mask write to 0 -> irq=0 next cycle.
6. Write DIR=8'h0F -> out_en=8'h0F. Assert reset_n=0 mid-cycle -> out_en, EDGECAP and irq clear asynchronously, without waiting for a clk edge.

Source files
------------

// File: rtl/niosqsys_gpio_pio.sv
// niosqsys_gpio_pio
// Avalon-MM slave GPIO port: configurable width, per-bit direction, atomic
// set/clear of the output register, synchronised inputs with edge capture
// and a maskable interrupt.
//
// Ports
//   clk, reset_n           system clock, async active-low reset
//   address[2:0]           register word address
//   chipselect, write_n    write strobe = chipselect & ~write_n
//   writedata[31:0]        write data, [WIDTH-1:0] used
//   readdata[31:0]         combinational read data, upper bits 0
//   in_port[WIDTH-1:0]     asynchronous pin inputs
//   out_port[WIDTH-1:0]    output data register
//   out_en[WIDTH-1:0]      per-bit pin drive enable
//   irq                    registered interrupt request
//
// Register map: 0 DATA, 1 DIR, 2 IRQMASK, 3 EDGECAP (W1C), 4 OUTSET,
// 5 OUTCLR, 6..7 reserved.

// Per-bit input lane: synchroniser, previous-sample flop, edge detect and
// the sticky capture bit.
module niosqsys_gpio_pio_lane #(
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  input  logic armed,
  input  logic clr,
  output logic s_last,
  output logic cap
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   edge_hit;

  assign s_last = sync[SYNC_STAGES-1];

  always_comb begin
    edge_hit = 1'b0;
    case (EDGE_TYPE)
      0:       edge_hit = s_last & ~prev;
      1:       edge_hit = ~s_last & prev;
      default: edge_hit = s_last ^ prev;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
      prev <= 1'b0;
      cap  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pin};
      prev <= s_last;
      // set has priority over a simultaneous write-1-to-clear
      cap  <= (cap & ~clr) | (edge_hit & armed);
    end
  end
endmodule

module niosqsys_gpio_pio #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          EDGE_TYPE   = 0,
  parameter int          IRQ_MODE    = 1,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_en,
  output logic             irq
);
  localparam logic [2:0] ARM_CYC = 3'(SYNC_STAGES + 1);

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] s_last;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] cap_clr;
  logic [2:0]       arm_cnt;
  logic             armed;
  logic             irq_nxt;
  logic             unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign cap_clr   = (wr_en && address == 3'd3) ? wd : '0;

  // Edges are ignored until the synchroniser and prev flop hold real pin
  // samples, so pins already high at reset do not look like rising edges.
  assign armed = (arm_cnt == ARM_CYC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    arm_cnt <= '0;
    else if (!armed) arm_cnt <= arm_cnt + 3'd1;
  end

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_lane
      niosqsys_gpio_pio_lane #(
        .EDGE_TYPE  (EDGE_TYPE),
        .SYNC_STAGES(SYNC_STAGES)
      ) u_lane (
        .clk    (clk),
        .reset_n(reset_n),
        .pin    (in_port[i]),
        .armed  (armed),
        .clr    (cap_clr[i]),
        .s_last (s_last[i]),
        .cap    (cap[i])
      );
    end
  endgenerate

  // Output data, direction and mask registers. out_port keeps updating
  // regardless of out_en; only the pin driver is gated externally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= RESET_VALUE[WIDTH-1:0];
      out_en   <= '0;
      irq_mask <= '0;
    end else if (wr_en) begin
      case (address)
        3'd0:    out_port <= wd;
        3'd1:    out_en   <= wd;
        3'd2:    irq_mask <= wd;
        3'd4:    out_port <= out_port | wd;
        3'd5:    out_port <= out_port & ~wd;
        default: ;
      endcase
    end
  end

  assign irq_nxt = (IRQ_MODE == 1) ? |(cap & irq_mask) : |(s_last & irq_mask);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= irq_nxt;
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata[WIDTH-1:0] = s_last;
      3'd1:    readdata[WIDTH-1:0] = out_en;
      3'd2:    readdata[WIDTH-1:0] = irq_mask;
      3'd3:    readdata[WIDTH-1:0] = cap;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_niosqsys_gpio_pio.sv
// Scoreboard bench: stimulus pushes expected values into a queue, the monitor
// pops and compares them on the next falling clock edge.
module tb_niosqsys_gpio_pio;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata, readdata_l;
  logic [7:0]  out_port, out_port_l, out_en, out_en_l;
  logic        irq, irq_l;

  always #5 clk = ~clk;

  niosqsys_gpio_pio #(.WIDTH(8), .RESET_VALUE(32'h3C), .EDGE_TYPE(0),
                      .IRQ_MODE(1), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .out_en(out_en), .irq(irq));

  // level-interrupt variant sharing the same bus and pins
  niosqsys_gpio_pio #(.WIDTH(8), .RESET_VALUE(32'h3C), .EDGE_TYPE(0),
                      .IRQ_MODE(0), .SYNC_STAGES(2)) u_lvl (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_l),
    .in_port(in_port), .out_port(out_port_l), .out_en(out_en_l), .irq(irq_l));

  typedef enum int {S_RD, S_OUT, S_OEN, S_IRQ, S_IRQL} sel_t;
  typedef struct {
    string       name;
    sel_t        sel;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  initial begin
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (q.size() != 0) begin
        c = q.pop_front();
        case (c.sel)
          S_RD:    act = readdata;
          S_OUT:   act = {24'h0, out_port};
          S_OEN:   act = {24'h0, out_en};
          S_IRQ:   act = {31'h0, irq};
          default: act = {31'h0, irq_l};
        endcase
        n_vec++;
        if (act !== c.exp) begin
          n_miss++;
          $display("FAIL %s: got %h, want %h (t=%0t)", c.name, act, c.exp, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string name, input sel_t sel, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    q.push_back(c);
  endtask

  task automatic chk_rd(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    expect_v(name, S_RD, exp);
    tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    int guard;
    reset_n    = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 8'hFF;
    #2 reset_n = 1'b0;
    tick();

    // 1: reset state with pins held high
    expect_v("rst_out_port", S_OUT, 32'h3C);
    expect_v("rst_out_en", S_OEN, 32'h0);
    expect_v("rst_irq", S_IRQ, 32'h0);
    chk_rd("rst_data", 3'd0, 32'h0);
    reset_n = 1'b1;
    tick();
    tick();
    chk_rd("data_ff", 3'd0, 32'hFF);
    for (int i = 0; i < 10; i++) chk_rd("edgecap_quiet", 3'd3, 32'h0);
    expect_v("quiet_irq", S_IRQ, 32'h0);
    expect_v("quiet_out_port", S_OUT, 32'h3C);

    // 2: data / set / clear
    wr(3'd0, 32'hA5);
    expect_v("out_a5", S_OUT, 32'hA5);
    wr(3'd4, 32'h0A);
    expect_v("out_set", S_OUT, 32'hAF);
    wr(3'd5, 32'h21);
    expect_v("out_clr", S_OUT, 32'h8E);
    chk_rd("rd_outset", 3'd4, 32'h0);
    chk_rd("rd_outclr", 3'd5, 32'h0);
    chk_rd("rd_rsvd6", 3'd6, 32'h0);

    // 3: rising capture and edge irq; falling ignored
    in_port = 8'hFE;
    repeat (5) tick();
    chk_rd("fall_ignored", 3'd3, 32'h0);
    wr(3'd2, 32'h01);
    chk_rd("rd_mask", 3'd2, 32'h01);
    in_port = 8'hFF;              // stable before edge k
    tick();                       // k
    tick();                       // k+1
    chk_rd("cap_early", 3'd3, 32'h0);
    expect_v("irq_early", S_IRQ, 32'h0);
    chk_rd("cap_k2", 3'd3, 32'h01);
    expect_v("irq_k3", S_IRQ, 32'h1);
    chk_rd("cap_hold", 3'd3, 32'h01);
    in_port = 8'hFE;
    repeat (4) tick();
    chk_rd("cap_after_fall", 3'd3, 32'h01);

    // 4: set wins over simultaneous clear, then plain clear
    in_port = 8'hFF;              // stable before edge k
    tick();                       // k
    tick();                       // k+1
    wr(3'd3, 32'h01);             // clear lands on edge k+2 with the rise
    chk_rd("cap_collide", 3'd3, 32'h01);
    wr(3'd3, 32'h01);
    expect_v("irq_lag", S_IRQ, 32'h1);
    chk_rd("cap_cleared", 3'd3, 32'h0);
    expect_v("irq_drop", S_IRQ, 32'h0);
    tick();

    // 5: level irq on the IRQ_MODE=0 instance
    in_port = 8'h7F;
    repeat (4) tick();
    wr(3'd2, 32'h80);
    tick();
    expect_v("lvl_idle", S_IRQL, 32'h0);
    tick();
    in_port = 8'hFF;              // stable before edge k
    tick();                       // k
    tick();                       // k+1
    expect_v("lvl_early", S_IRQL, 32'h0);
    tick();                       // k+2
    expect_v("lvl_set", S_IRQL, 32'h1);
    wr(3'd2, 32'h00);
    expect_v("lvl_mask_lag", S_IRQL, 32'h1);
    tick();
    expect_v("lvl_masked", S_IRQL, 32'h0);
    tick();

    // 6: direction, then asynchronous reset mid-cycle
    wr(3'd1, 32'h0F);
    expect_v("out_en_0f", S_OEN, 32'h0F);
    chk_rd("rd_dir", 3'd1, 32'h0F);
    wr(3'd2, 32'h80);
    tick();
    expect_v("irq_pre_rst", S_IRQ, 32'h1);
    chk_rd("cap_pre_rst", 3'd3, 32'h80);
    #1 reset_n = 1'b0;            // checked before any further rising edge
    expect_v("arst_cap", S_RD, 32'h0);
    expect_v("arst_out_en", S_OEN, 32'h0);
    expect_v("arst_irq", S_IRQ, 32'h0);
    expect_v("arst_out_port", S_OUT, 32'h3C);
    tick();
    reset_n = 1'b1;
    tick();

    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    if (q.size() != 0) begin
      $display("FAIL drain: %0d checks pending, want 0", q.size());
      n_miss += q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
